pc_stack_unit: RTL and testbench

//  Parametrised program-counter unit for the PIC_RISC core: increment, skip, jump, call/return

---
 rtl/pc_pkg.sv | 29 ++
 rtl/ret_addr_stack.sv | 72 +++++++
 rtl/pc_stack_unit.sv | 103 ++++++++++
 tb/tb_pc_stack_unit.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared defaults and the one-hot-in-spirit action select for the PIC_RISC program-counter unit.
package pc_pkg;

  localparam int unsigned PC_ADDR_W    = 14;
  localparam int unsigned PC_RESET_VEC = 0;
  localparam int unsigned PC_INT_VEC   = 4;

  typedef enum logic [2:0] {
    ACT_INT,
    ACT_RET,
    ACT_CALL,
    ACT_JMP,
    ACT_SKIP,
    ACT_INC
  } pc_action_e;

  // Strobes are listed high to low priority; anything below the winner is dropped.
  function automatic pc_action_e decode_action(input logic int_take, input logic ret,
                                               input logic call, input logic jmp,
                                               input logic skp);
    if (int_take) return ACT_INT;
    if (ret)      return ACT_RET;
    if (call)     return ACT_CALL;
    if (jmp)      return ACT_JMP;
    if (skp)      return ACT_SKIP;
    return ACT_INC;
  endfunction

endpackage

// File: rtl/ret_addr_stack.sv
// Circular LIFO of return addresses: a full push overwrites the oldest entry, an empty pop is refused.
module ret_addr_stack
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W      = PC_ADDR_W,
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [ADDR_W-1:0] i_push_data,
  output logic [ADDR_W-1:0] o_top_data,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_overflow,
  output logic              o_underflow
);

  localparam int unsigned PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(STACK_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(STACK_DEPTH);

  logic [ADDR_W-1:0] r_mem [STACK_DEPTH];
  logic [PTR_W-1:0]  r_wp;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;
  logic              r_underflow;
  logic [PTR_W-1:0]  w_top_idx;
  logic [PTR_W-1:0]  w_wp_inc;

  // r_wp is the next free slot; the newest entry sits just below it, wrapping.
  assign w_top_idx  = (r_wp == '0) ? LAST_IDX : r_wp - PTR_W'(1);
  assign w_wp_inc   = (r_wp == LAST_IDX) ? '0 : r_wp + PTR_W'(1);
  assign o_top_data = r_mem[w_top_idx];
  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == FULL_CNT);
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wp] <= i_push_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wp        <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (i_clear) begin
      r_wp        <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (i_push) begin
      r_wp <= w_wp_inc;
      if (o_full) r_overflow <= 1'b1;
      else        r_count    <= r_count + CNT_W'(1);
    end else if (i_pop) begin
      if (o_empty) begin
        r_underflow <= 1'b1;
      end else begin
        r_wp    <= w_top_idx;
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with skip/jump/call/return, hardware return stack and single-level interrupt entry.
module pc_stack_unit
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W      = PC_ADDR_W,
  parameter int unsigned STACK_DEPTH = 8,
  parameter int unsigned RESET_VEC   = PC_RESET_VEC,
  parameter int unsigned INT_VEC     = PC_INT_VEC
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              update_pc,
  input  logic              jump_enable,
  input  logic              call_enable,
  input  logic              ret_enable,
  input  logic              ret_int,
  input  logic              skip,
  input  logic              int_req,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] PC,
  output logic              int_busy,
  output logic              stack_empty,
  output logic              stack_full,
  output logic              stack_overflow,
  output logic              stack_underflow
);

  localparam logic [ADDR_W-1:0] RV = ADDR_W'(RESET_VEC);
  localparam logic [ADDR_W-1:0] IV = ADDR_W'(INT_VEC);

  logic [ADDR_W-1:0] r_pc;
  logic              r_int_busy;
  pc_action_e        w_act;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_push_data;
  logic [ADDR_W-1:0] w_pc_next;
  logic [ADDR_W-1:0] w_top_data;

  assign w_act = decode_action(int_req & ~r_int_busy, ret_enable, call_enable,
                               jump_enable, skip);

  always_comb begin
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_push_data = r_pc + ADDR_W'(1);
    w_pc_next   = r_pc + ADDR_W'(1);
    case (w_act)
      ACT_INT: begin
        w_push      = 1'b1;
        w_push_data = r_pc;
        w_pc_next   = IV;
      end
      ACT_RET: begin
        w_pop     = 1'b1;
        w_pc_next = stack_empty ? RV : w_top_data;
      end
      ACT_CALL: begin
        w_push    = 1'b1;
        w_pc_next = jump_addr;
      end
      ACT_JMP:  w_pc_next = jump_addr;
      ACT_SKIP: w_pc_next = r_pc + ADDR_W'(2);
      default:  w_pc_next = r_pc + ADDR_W'(1);
    endcase
  end

  ret_addr_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .i_clk       (clock),
    .i_rst_n     (reset),
    .i_clear     (clear),
    .i_push      (w_push & update_pc),
    .i_pop       (w_pop & update_pc),
    .i_push_data (w_push_data),
    .o_top_data  (w_top_data),
    .o_empty     (stack_empty),
    .o_full      (stack_full),
    .o_overflow  (stack_overflow),
    .o_underflow (stack_underflow)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc       <= RV;
      r_int_busy <= 1'b0;
    end else if (clear) begin
      r_pc       <= RV;
      r_int_busy <= 1'b0;
    end else if (update_pc) begin
      r_pc <= w_pc_next;
      if (w_act == ACT_INT)                r_int_busy <= 1'b1;
      else if (w_act == ACT_RET && ret_int) r_int_busy <= 1'b0;
    end
  end

  assign PC       = r_pc;
  assign int_busy = r_int_busy;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit: one task per scenario, expected values worked out by hand.
module tb_pc_stack_unit;

  localparam int unsigned ADDR_W = 14;

  logic              clock = 1'b0;
  logic              reset;
  logic              clear;
  logic              update_pc;
  logic              jump_enable;
  logic              call_enable;
  logic              ret_enable;
  logic              ret_int;
  logic              skip;
  logic              int_req;
  logic [ADDR_W-1:0] jump_addr;
  logic [ADDR_W-1:0] PC;
  logic              int_busy;
  logic              stack_empty;
  logic              stack_full;
  logic              stack_overflow;
  logic              stack_underflow;

  int tests_run = 0;
  int tests_failed = 0;

  pc_stack_unit #(
    .ADDR_W(ADDR_W), .STACK_DEPTH(8), .RESET_VEC(0), .INT_VEC(4)
  ) dut (
    .clock(clock), .reset(reset), .clear(clear), .update_pc(update_pc),
    .jump_enable(jump_enable), .call_enable(call_enable), .ret_enable(ret_enable),
    .ret_int(ret_int), .skip(skip), .int_req(int_req), .jump_addr(jump_addr),
    .PC(PC), .int_busy(int_busy), .stack_empty(stack_empty), .stack_full(stack_full),
    .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    update_pc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (PC !== 14'd0 || stack_empty !== 1'b1 || int_busy !== 1'b0 || stack_full !== 1'b0 ||
          stack_overflow !== 1'b0 || stack_underflow !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_hold cyc%0d: PC=%0d empty=%b busy=%b full=%b ovf=%b unf=%b, want PC=0 empty=1 others 0",
                 i, PC, stack_empty, int_busy, stack_full, stack_overflow, stack_underflow);
      end
    end
    reset = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      tests_run++;
      if (PC !== ADDR_W'(i) || stack_empty !== 1'b1) begin
        tests_failed++;
        $display("FAIL reset_release_inc: PC=%0d empty=%b, want PC=%0d empty=1", PC, stack_empty, i);
      end
    end
  endtask

  task automatic test_jump_hold();
    jump_enable = 1'b1;
    jump_addr = 14'd12765;
    tick();
    jump_enable = 1'b0;
    tests_run++;
    if (PC !== 14'd12765) begin
      tests_failed++;
      $display("FAIL jump_load: PC=%0d, want 12765", PC);
    end
    tick();
    tests_run++;
    if (PC !== 14'd12766) begin
      tests_failed++;
      $display("FAIL jump_then_inc: PC=%0d, want 12766", PC);
    end
    update_pc = 1'b0;
    tick();
    tick();
    tests_run++;
    if (PC !== 14'd12766) begin
      tests_failed++;
      $display("FAIL update_hold: PC=%0d, want 12766", PC);
    end
    update_pc = 1'b1;
  endtask

  task automatic test_nested_calls();
    do_clear();
    for (int k = 0; k < 9; k++) begin
      call_enable = 1'b1;
      jump_addr = ADDR_W'(100 + k);
      tick();
      tests_run++;
      if (PC !== ADDR_W'(100 + k)) begin
        tests_failed++;
        $display("FAIL call_target k=%0d: PC=%0d, want %0d", k, PC, 100 + k);
      end
      if (k == 7) begin
        tests_run++;
        if (stack_full !== 1'b1 || stack_overflow !== 1'b0) begin
          tests_failed++;
          $display("FAIL call_full8: full=%b ovf=%b, want full=1 ovf=0", stack_full, stack_overflow);
        end
      end
    end
    call_enable = 1'b0;
    tests_run++;
    if (stack_full !== 1'b1 || stack_overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL call_overflow9: full=%b ovf=%b, want full=1 ovf=1", stack_full, stack_overflow);
    end
    // Pushed 1,101..108; the 1 was overwritten, so pops give 108 down to 101.
    for (int k = 0; k < 8; k++) begin
      ret_enable = 1'b1;
      tick();
      tests_run++;
      if (PC !== ADDR_W'(108 - k)) begin
        tests_failed++;
        $display("FAIL ret_lifo k=%0d: PC=%0d, want %0d", k, PC, 108 - k);
      end
    end
    ret_enable = 1'b0;
    tests_run++;
    if (stack_empty !== 1'b1 || stack_full !== 1'b0) begin
      tests_failed++;
      $display("FAIL ret_drained: empty=%b full=%b, want empty=1 full=0", stack_empty, stack_full);
    end
  endtask

  task automatic test_underflow_clear();
    ret_enable = 1'b1;
    tick();
    ret_enable = 1'b0;
    tests_run++;
    if (PC !== 14'd0 || stack_underflow !== 1'b1 || stack_empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL underflow_pop: PC=%0d unf=%b empty=%b, want PC=0 unf=1 empty=1",
               PC, stack_underflow, stack_empty);
    end
    tick();
    tick();
    tests_run++;
    if (PC !== 14'd2 || stack_underflow !== 1'b1 || stack_overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL sticky_flags: PC=%0d unf=%b ovf=%b, want PC=2 unf=1 ovf=1",
               PC, stack_underflow, stack_overflow);
    end
    do_clear();
    tests_run++;
    if (PC !== 14'd0 || stack_underflow !== 1'b0 || stack_overflow !== 1'b0 || stack_empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL clear_flags: PC=%0d unf=%b ovf=%b empty=%b, want PC=0 unf=0 ovf=0 empty=1",
               PC, stack_underflow, stack_overflow, stack_empty);
    end
  endtask

  task automatic test_interrupt();
    jump_enable = 1'b1;
    jump_addr = 14'h0100;
    tick();
    jump_enable = 1'b0;
    int_req = 1'b1;
    tick();
    tests_run++;
    if (PC !== 14'd4 || int_busy !== 1'b1 || stack_empty !== 1'b0) begin
      tests_failed++;
      $display("FAIL int_entry: PC=%0d busy=%b empty=%b, want PC=4 busy=1 empty=0", PC, int_busy, stack_empty);
    end
    tick();
    tests_run++;
    if (PC !== 14'd5 || int_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL int_no_nest: PC=%0d busy=%b, want PC=5 busy=1", PC, int_busy);
    end
    int_req = 1'b0;
    ret_int = 1'b1;
    tick();
    tests_run++;
    if (PC !== 14'd6 || int_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL retint_alone: PC=%0d busy=%b, want PC=6 busy=1", PC, int_busy);
    end
    int_req = 1'b1;
    ret_enable = 1'b1;
    tick();
    ret_enable = 1'b0;
    ret_int = 1'b0;
    tests_run++;
    if (PC !== 14'h0100 || int_busy !== 1'b0 || stack_empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL int_return: PC=%0d busy=%b empty=%b, want PC=256 busy=0 empty=1", PC, int_busy, stack_empty);
    end
    tick();
    int_req = 1'b0;
    tests_run++;
    if (PC !== 14'd4 || int_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL int_held_retaken: PC=%0d busy=%b, want PC=4 busy=1", PC, int_busy);
    end
    ret_enable = 1'b1;
    ret_int = 1'b1;
    tick();
    ret_enable = 1'b0;
    ret_int = 1'b0;
    tests_run++;
    if (PC !== 14'h0100 || int_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL int_return2: PC=%0d busy=%b, want PC=256 busy=0", PC, int_busy);
    end
    do_clear();
  endtask

  task automatic test_boundaries();
    jump_enable = 1'b1;
    jump_addr = 14'd16383;
    tick();
    jump_enable = 1'b0;
    tick();
    tests_run++;
    if (PC !== 14'd0) begin
      tests_failed++;
      $display("FAIL inc_wrap: PC=%0d, want 0", PC);
    end
    jump_enable = 1'b1;
    jump_addr = 14'd16382;
    tick();
    jump_enable = 1'b0;
    skip = 1'b1;
    tick();
    skip = 1'b0;
    tests_run++;
    if (PC !== 14'd0) begin
      tests_failed++;
      $display("FAIL skip_wrap: PC=%0d, want 0", PC);
    end
    call_enable = 1'b1;
    jump_enable = 1'b1;
    skip = 1'b1;
    jump_addr = 14'd200;
    tick();
    call_enable = 1'b0;
    jump_enable = 1'b0;
    skip = 1'b0;
    tests_run++;
    if (PC !== 14'd200 || stack_empty !== 1'b0) begin
      tests_failed++;
      $display("FAIL call_priority: PC=%0d empty=%b, want PC=200 empty=0", PC, stack_empty);
    end
    ret_enable = 1'b1;
    tick();
    ret_enable = 1'b0;
    tests_run++;
    if (PC !== 14'd1 || stack_empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL call_priority_ret: PC=%0d empty=%b, want PC=1 empty=1", PC, stack_empty);
    end
  endtask

  task automatic test_reset_mid_call();
    call_enable = 1'b1;
    jump_addr = 14'd300;
    tick();
    tests_run++;
    if (PC !== 14'd300) begin
      tests_failed++;
      $display("FAIL pre_reset_call: PC=%0d, want 300", PC);
    end
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if (PC !== 14'd0 || stack_empty !== 1'b1 || int_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: PC=%0d empty=%b busy=%b, want PC=0 empty=1 busy=0", PC, stack_empty, int_busy);
    end
    tick();
    tests_run++;
    if (PC !== 14'd0 || stack_empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_held_call: PC=%0d empty=%b, want PC=0 empty=1", PC, stack_empty);
    end
    call_enable = 1'b0;
    reset = 1'b1;
    tick();
    tests_run++;
    if (PC !== 14'd1) begin
      tests_failed++;
      $display("FAIL post_reset_inc: PC=%0d, want 1", PC);
    end
  endtask

  initial begin
    reset = 1'b0;
    clear = 1'b0;
    update_pc = 1'b0;
    jump_enable = 1'b0;
    call_enable = 1'b0;
    ret_enable = 1'b0;
    ret_int = 1'b0;
    skip = 1'b0;
    int_req = 1'b0;
    jump_addr = '0;
    test_reset();
    test_jump_hold();
    test_nested_calls();
    test_underflow_clear();
    test_interrupt();
    test_boundaries();
    test_reset_mid_call();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
